c_bus_sched: RTL and testbench
==============================

// Module: c_bus_sched
// PURPOSE
//   Round-robin scheduler owning the 8-bit C bus. Four sources (PC, MDR, IR, R) request the bus; one is granted at a time.
//   Drives the 2-bit C-bus mux select, a one-hot grant back to the requesters, and a bus-valid strobe for destination latches.
//   Sits between the control unit's transfer requests and the C-bus mux in the processor datapath.
// PARAMETERS
//   HOLD_MAX   8   max consecutive GRANT cycles per tenure (used only with C_BUS_HOLD_LIMIT_EN); legal 1..255
//   CNT_W      8   width of hold counter; must satisfy 2**CNT_W > HOLD_MAX
// PORTS
//   clk        in   1  system clock, rising edge
//   rst        in   1  asynchronous reset, active-high
//   req        in   4  bus requests; bit0=PC, bit1=MDR, bit2=IR, bit3=R (same index as mux select code)
//   gnt        out  4  one-hot grant, registered; all-zero when no owner
//   sel        out  2  C-bus mux select, registered; equals index of current/last owner
//   bus_valid  out  1  high exactly when gnt != 0; destinations latch C bus on clk edge while high
//   busy       out  1  high in GRANT state
//   hold_cnt   out  CNT_W  cycles elapsed in current tenure (0 in IDLE)
// BEHAVIOUR
//   Reset (async, rst=1): state=IDLE, gnt=0, sel=2'b00, bus_valid=0, busy=0, hold_cnt=0, rr pointer last=2'd3 (so PC wins first).
//   States: IDLE, GRANT. All outputs registered; no combinational path req->gnt.
//   IDLE: if req!=0, pick winner = first set bit scanning last+1, last+2, ... (mod 4); next edge: gnt=1<<winner, sel=winner,
//     bus_valid=1, busy=1, hold_cnt=0, last=winner, state=GRANT. If req==0 stay IDLE, sel holds previous value.
//   GRANT: owner keeps bus while req[owner]=1; hold_cnt increments per cycle, saturating at 2**CNT_W-1.
//     Release when req[owner]=0 on a sampling edge: next cycle gnt=0, bus_valid=0, busy=0, hold_cnt=0, state=IDLE; sel unchanged.
//   Latency: req asserted in IDLE -> gnt 1 cycle later. Release -> next grant: 2 cycles (one mandatory dead cycle, no bus contention).
//   Requests from non-owners during GRANT are ignored (not queued); they are arbitrated in the next IDLE cycle.
//   Owner dropping req in the same cycle another asserts: owner released, IDLE cycle, then rr pick excluding nobody (owner now last).
//   Fairness: with all four requesting and single-cycle tenures, grant order PC, MDR, IR, R, PC, ... repeating.
//   Reset mid-tenure: gnt/bus_valid drop immediately (async); pointer returns to 3.
//   Invariants: $onehot0(gnt); bus_valid==|gnt; busy==(state==GRANT); gnt!=0 implies gnt==1<<sel.
// CONFIGURATION
//   C_BUS_HOLD_LIMIT_EN defined: in GRANT, when hold_cnt==HOLD_MAX-1 the tenure is force-ended next edge even if req[owner]=1
//     (owner sees gnt fall, may re-request; rr pointer ensures other pending sources are served first).
//   Not defined: tenure unlimited; HOLD_MAX ignored; hold_cnt still counts and saturates.
// STRUCTURE
//   c_bus_pkg: SRC_PC=2'd0, SRC_MDR=2'd1, SRC_IR=2'd2, SRC_R=2'd3; state encoding ST_IDLE=1'b0, ST_GRANT=1'b1.
//   Sub-module rr_pick4: combinational, inputs req[3:0], last[1:0]; outputs any, win[1:0]. Top holds FSM, registers, counter.
// TESTING
//   1 Reset then req=4'b1111 held, release each owner after 1 cycle -> sel sequence 0,1,2,3,0 with one dead cycle between grants.
//   2 req=4'b0100 for 5 cycles -> gnt=4'b0100 from cycle 1, sel=2, hold_cnt 0..4, bus_valid=1; drop req -> gnt=0 next cycle, sel stays 2.
//   3 MDR owns, R asserts mid-tenure -> R not granted until MDR drops; then IDLE one cycle, gnt=4'b1000.
//   4 With C_BUS_HOLD_LIMIT_EN, HOLD_MAX=3, PC and IR held high -> PC granted 3 cycles, forced release, IR granted next; without macro PC keeps bus.
//   5 Assert rst during GRANT (IR owner) -> gnt=0, sel=0, bus_valid=0 same cycle, no edge needed; after release with req=4'b1111 PC wins.
//   6 Random req for 10k cycles -> invariants hold every cycle; no requester held pending >3 tenures (all-fair check).

Source files
------------

// File: rtl/c_bus_sched_pkg.sv
// Shared constants and types for the C-bus scheduler: source codes, FSM state encoding, grant helper.
package c_bus_pkg;

  localparam int unsigned NSRC  = 4;
  localparam int unsigned SEL_W = 2;

  localparam logic [SEL_W-1:0] SRC_PC  = 2'd0;
  localparam logic [SEL_W-1:0] SRC_MDR = 2'd1;
  localparam logic [SEL_W-1:0] SRC_IR  = 2'd2;
  localparam logic [SEL_W-1:0] SRC_R   = 2'd3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // One-hot grant vector for a source index
  function automatic logic [NSRC-1:0] onehot4(input logic [SEL_W-1:0] idx);
    return NSRC'(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/c_bus_sched_if.sv
// C-bus request/grant bundle between the requesters (master) and the scheduler (slave).
interface c_bus_sched_if #(
  parameter int unsigned CNT_W = 8
);
  logic [3:0]       req;
  logic [3:0]       gnt;
  logic [1:0]       sel;
  logic             bus_valid;
  logic             busy;
  logic [CNT_W-1:0] hold_cnt;

  modport master (output req, input gnt, sel, bus_valid, busy, hold_cnt);
  modport slave  (input req, output gnt, sel, bus_valid, busy, hold_cnt);
endinterface

// File: rtl/c_bus_sched_rr_pick4.sv
// Combinational round-robin picker: first requesting source scanning last+1, last+2, ... mod 4.
module rr_pick4
  import c_bus_pkg::*;
(
  input  logic [NSRC-1:0]  req,
  input  logic [SEL_W-1:0] last,
  output logic             any,
  output logic [SEL_W-1:0] win
);

  logic [SEL_W-1:0] idx;
  logic             found;

  always_comb begin
    any   = |req;
    win   = last;
    idx   = '0;
    found = 1'b0;
    for (int i = 1; i <= int'(NSRC); i++) begin
      idx = last + SEL_W'(i);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/c_bus_sched.sv
// Round-robin owner of the 8-bit C bus: IDLE/GRANT FSM, registered grant/select/valid, tenure counter.
// Optional build macro C_BUS_HOLD_LIMIT_EN force-ends a tenure after HOLD_MAX grant cycles.
module c_bus_sched
  import c_bus_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 8,
  parameter int unsigned CNT_W    = 8
)(
  input  logic            clk,
  input  logic            rst,
  c_bus_sched_if.slave    bus
);

`ifdef C_BUS_HOLD_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};

  state_e           state;
  logic [SEL_W-1:0] last;
  logic             pick_any;
  logic [SEL_W-1:0] pick_win;
  logic             owner_req_c;
  logic             limit_hit_c;

  rr_pick4 u_pick (
    .req  (bus.req),
    .last (last),
    .any  (pick_any),
    .win  (pick_win)
  );

  assign owner_req_c = bus.req[bus.sel];
  assign limit_hit_c = LIMIT_EN && (bus.hold_cnt == HOLD_LAST);

  // FSM and all registered outputs; sel is deliberately left untouched on release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      last          <= SRC_R;
      bus.gnt       <= '0;
      bus.sel       <= SRC_PC;
      bus.bus_valid <= 1'b0;
      bus.busy      <= 1'b0;
      bus.hold_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            state         <= ST_GRANT;
            last          <= pick_win;
            bus.gnt       <= onehot4(pick_win);
            bus.sel       <= pick_win;
            bus.bus_valid <= 1'b1;
            bus.busy      <= 1'b1;
            bus.hold_cnt  <= '0;
          end
        end
        ST_GRANT: begin
          if (!owner_req_c || limit_hit_c) begin
            state         <= ST_IDLE;
            bus.gnt       <= '0;
            bus.bus_valid <= 1'b0;
            bus.busy      <= 1'b0;
            bus.hold_cnt  <= '0;
          end else if (bus.hold_cnt != CNT_SAT) begin
            bus.hold_cnt <= bus.hold_cnt + CNT_W'(1);
          end
        end
        default: begin
          state         <= ST_IDLE;
          bus.gnt       <= '0;
          bus.bus_valid <= 1'b0;
          bus.busy      <= 1'b0;
          bus.hold_cnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_c_bus_sched.sv
// Directed and randomized self-checking bench for c_bus_sched (HOLD_MAX=3, CNT_W=8).
module tb_c_bus_sched;
  import c_bus_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nvec = 0;
  int   nerr = 0;

  c_bus_sched_if #(.CNT_W(8)) bus ();

  c_bus_sched #(.HOLD_MAX(3), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Observed outputs packed as {gnt, sel, bus_valid, busy, hold_cnt}
  function automatic logic [15:0] snap();
    return {bus.gnt, bus.sel, bus.bus_valid, bus.busy, bus.hold_cnt};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [15:0] exp;
    rst = 1'b1;
    bus.req = 4'b0000;
    repeat (3) @(posedge clk);
    #4 rst = 1'b0;
    step();
    exp = {4'b0000, 2'd0, 1'b0, 1'b0, 8'd0};
    nvec++;
    if (snap() !== exp) begin
      nerr++;
      $display("FAIL reset got=%h exp=%h", snap(), exp);
    end
  endtask

  task automatic test_rr_order();
    logic [15:0] exp;
    logic [1:0]  s;
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      s = 2'(k % 4);
      step();
      exp = {onehot4(s), s, 1'b1, 1'b1, 8'd0};
      nvec++;
      if (snap() !== exp) begin
        nerr++;
        $display("FAIL rr_grant k=%0d got=%h exp=%h", k, snap(), exp);
      end
      bus.req = 4'b1111 & ~onehot4(s);
      step();
      exp = {4'b0000, s, 1'b0, 1'b0, 8'd0};
      nvec++;
      if (snap() !== exp) begin
        nerr++;
        $display("FAIL rr_dead k=%0d got=%h exp=%h", k, snap(), exp);
      end
      bus.req = 4'b1111;
    end
    bus.req = 4'b0000;
    step();
  endtask

  task automatic test_hold_count();
    logic [15:0] exp;
    bus.req = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      step();
      exp = {4'b0100, 2'd2, 1'b1, 1'b1, 8'(i)};
      nvec++;
      if (snap() !== exp) begin
        nerr++;
        $display("FAIL hold i=%0d got=%h exp=%h", i, snap(), exp);
      end
    end
    bus.req = 4'b0000;
    step();
    exp = {4'b0000, 2'd2, 1'b0, 1'b0, 8'd0};
    nvec++;
    if (snap() !== exp) begin
      nerr++;
      $display("FAIL hold_release got=%h exp=%h", snap(), exp);
    end
  endtask

  task automatic test_no_preempt();
    logic [15:0] exp;
    bus.req = 4'b0010;
    step();
    exp = {4'b0010, 2'd1, 1'b1, 1'b1, 8'd0};
    nvec++;
    if (snap() !== exp) begin
      nerr++;
      $display("FAIL mdr_grant got=%h exp=%h", snap(), exp);
    end
    bus.req = 4'b1010;
    for (int i = 1; i <= 2; i++) begin
      step();
      exp = {4'b0010, 2'd1, 1'b1, 1'b1, 8'(i)};
      nvec++;
      if (snap() !== exp) begin
        nerr++;
        $display("FAIL mdr_keep i=%0d got=%h exp=%h", i, snap(), exp);
      end
    end
    bus.req = 4'b1000;
    step();
    exp = {4'b0000, 2'd1, 1'b0, 1'b0, 8'd0};
    nvec++;
    if (snap() !== exp) begin
      nerr++;
      $display("FAIL mdr_dead got=%h exp=%h", snap(), exp);
    end
    step();
    exp = {4'b1000, 2'd3, 1'b1, 1'b1, 8'd0};
    nvec++;
    if (snap() !== exp) begin
      nerr++;
      $display("FAIL r_grant got=%h exp=%h", snap(), exp);
    end
    bus.req = 4'b0000;
    step();
  endtask

  task automatic test_hold_limit();
    logic [15:0] exp;
    bus.req = 4'b0101;
`ifdef C_BUS_HOLD_LIMIT_EN
    for (int i = 0; i < 3; i++) begin
      step();
      exp = {4'b0001, 2'd0, 1'b1, 1'b1, 8'(i)};
      nvec++;
      if (snap() !== exp) begin
        nerr++;
        $display("FAIL limit_pc i=%0d got=%h exp=%h", i, snap(), exp);
      end
    end
    step();
    exp = {4'b0000, 2'd0, 1'b0, 1'b0, 8'd0};
    nvec++;
    if (snap() !== exp) begin
      nerr++;
      $display("FAIL limit_force got=%h exp=%h", snap(), exp);
    end
    step();
    exp = {4'b0100, 2'd2, 1'b1, 1'b1, 8'd0};
    nvec++;
    if (snap() !== exp) begin
      nerr++;
      $display("FAIL limit_ir got=%h exp=%h", snap(), exp);
    end
`else
    for (int i = 0; i < 6; i++) begin
      step();
      exp = {4'b0001, 2'd0, 1'b1, 1'b1, 8'(i)};
      nvec++;
      if (snap() !== exp) begin
        nerr++;
        $display("FAIL nolimit_pc i=%0d got=%h exp=%h", i, snap(), exp);
      end
    end
`endif
    bus.req = 4'b0000;
    step();
    step();
  endtask

  task automatic test_async_reset();
    logic [15:0] exp;
    bus.req = 4'b0100;
    step();
    exp = {4'b0100, 2'd2, 1'b1, 1'b1, 8'd0};
    nvec++;
    if (snap() !== exp) begin
      nerr++;
      $display("FAIL rst_pre got=%h exp=%h", snap(), exp);
    end
    #2 rst = 1'b1;
    #1;
    exp = {4'b0000, 2'd0, 1'b0, 1'b0, 8'd0};
    nvec++;
    if (snap() !== exp) begin
      nerr++;
      $display("FAIL rst_async got=%h exp=%h", snap(), exp);
    end
    bus.req = 4'b1111;
    #1 rst = 1'b0;
    step();
    exp = {4'b0001, 2'd0, 1'b1, 1'b1, 8'd0};
    nvec++;
    if (snap() !== exp) begin
      nerr++;
      $display("FAIL rst_pc_first got=%h exp=%h", snap(), exp);
    end
    bus.req = 4'b0000;
    step();
  endtask

  task automatic test_random();
    logic [3:0] r;
    logic       was_idle;
    int         miss [4];
    for (int i = 0; i < 4; i++) miss[i] = 0;
    for (int c = 0; c < 10000; c++) begin
      r = 4'($urandom);
      if (bus.busy && ($urandom_range(0, 3) != 0)) r[bus.sel] = 1'b1;
      bus.req  = r;
      was_idle = !bus.busy;
      step();
      nvec++;
      if (!$onehot0(bus.gnt) || (bus.bus_valid !== (|bus.gnt)) || (bus.busy !== bus.bus_valid) ||
          ((bus.gnt != 4'b0000) && (bus.gnt !== onehot4(bus.sel)))) begin
        nerr++;
        $display("FAIL invariant c=%0d gnt=%b sel=%0d bv=%b busy=%b", c, bus.gnt, bus.sel, bus.bus_valid, bus.busy);
      end
      if (was_idle) begin
        nvec++;
        if ((bus.gnt != 4'b0000) !== (r != 4'b0000)) begin
          nerr++;
          $display("FAIL idle_grant c=%0d req=%b gnt=%b", c, r, bus.gnt);
        end
        if (r != 4'b0000) begin
          for (int s = 0; s < 4; s++) begin
            if (!r[s] || (bus.sel == 2'(s))) miss[s] = 0;
            else miss[s]++;
            nvec++;
            if (miss[s] > 3) begin
              nerr++;
              $display("FAIL fairness c=%0d src=%0d passed_over=%0d max=3", c, s, miss[s]);
            end
          end
        end
      end
    end
    bus.req = 4'b0000;
    step();
    step();
  endtask

  initial begin
    bus.req = 4'b0000;
    test_reset();
    test_rr_order();
    test_hold_count();
    test_no_preempt();
    test_hold_limit();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
